rv32i_multicycle_ctrl: RTL and testbench

Multi-cycle control unit for the RV32I core; successor to the single-cycle control_unit decoder.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Handshakes with instruction and data memory, which may insert wait states.
- Bus timeout and illegal-type detection.
- Drives the existing 6-bit ctrl_wrd datapath interface, with register and memory strobes gated to the correct phase.

---
 rtl/rv32i_multicycle_ctrl_if.sv | 28 ++
 rtl/rv32i_multicycle_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_rv32i_multicycle_ctrl.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv32i_multicycle_ctrl_if.sv
// Memory handshake bundle between the multi-cycle controller and the instruction/data memories.
//   imem_req    : controller requests an instruction word (FETCH)
//   imem_ready  : instruction word valid this cycle
//   type_select : opcode[6:2] of the instruction word, valid while imem_ready=1
//   dmem_ready  : data access completes this cycle
// The master modport is the controller side; the slave modport is the memory side.
interface rv32i_multicycle_ctrl_if #(
  parameter int unsigned TYPE_W = 5
);
  logic              imem_req;
  logic              imem_ready;
  logic [TYPE_W-1:0] type_select;
  logic              dmem_ready;

  modport master (
    output imem_req,
    input  imem_ready,
    input  type_select,
    input  dmem_ready
  );

  modport slave (
    input  imem_req,
    output imem_ready,
    output type_select,
    output dmem_ready
  );
endinterface

// File: rtl/rv32i_multicycle_ctrl.sv
// Multi-cycle control unit for the RV32I core. Sequences each instruction through
// FETCH/DECODE/EXEC/MEM/WB, waits on instruction/data memory ready, detects bus timeouts
// and drives the 6-bit ctrl_wrd datapath control word with strobes gated to the right phase.
//
// Ports:
//   clk       : rising-edge clock
//   rst_n     : synchronous active-low reset
//   bus       : memory handshake (imem_req, imem_ready, type_select, dmem_ready), master side
//   ctrl_wrd  : {s_inc_imm_i_PC, s_reg_imm_ALU_B, s_ALU_dmem_wregdata,
//                sig_w_ctrl_reg, sig_r_ctrl_data_mem, sig_w_ctrl_data_mem}
//   ir_we     : latch the instruction register
//   pc_we     : update PC, asserted in the last cycle of each instruction
//   state     : current FSM state (debug)
//   bus_fault : sticky, a memory wait exceeded MEM_TIMEOUT cycles
//   illegal   : sticky, an unknown instruction type was decoded
//   halted    : FSM is in TRAP (left only by reset)
//
// Optional feature macro: CTRL_ILLEGAL_TRAP_EN. When defined, an unknown type traps in DECODE
// and sets illegal. When undefined, an unknown type executes as a 3-cycle NOP and illegal is 0.
module rv32i_multicycle_ctrl #(
  parameter int unsigned TYPE_W      = 5,
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 5
) (
  input  logic                          clk,
  input  logic                          rst_n,
  rv32i_multicycle_ctrl_if.master       bus,
  output logic [5:0]                    ctrl_wrd,
  output logic                          ir_we,
  output logic                          pc_we,
  output logic [2:0]                    state,
  output logic                          bus_fault,
  output logic                          illegal,
  output logic                          halted
);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StTrap   = 3'd5
  } state_e;

  localparam logic [TYPE_W-1:0] TyLui   = TYPE_W'(5'b01101);
  localparam logic [TYPE_W-1:0] TyAuipc = TYPE_W'(5'b00101);
  localparam logic [TYPE_W-1:0] TyJal   = TYPE_W'(5'b11011);
  localparam logic [TYPE_W-1:0] TyJalr  = TYPE_W'(5'b11001);
  localparam logic [TYPE_W-1:0] TyLoad  = TYPE_W'(5'b00000);
  localparam logic [TYPE_W-1:0] TyStore = TYPE_W'(5'b01000);
  localparam logic [TYPE_W-1:0] TyRimm  = TYPE_W'(5'b00100);
  localparam logic [TYPE_W-1:0] TyR     = TYPE_W'(5'b01100);
  localparam logic [TYPE_W-1:0] TyB     = TYPE_W'(5'b11000);

  localparam bit               TimeoutEn = (MEM_TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CntLast   = TimeoutEn ? CNT_W'(MEM_TIMEOUT - 1) : '0;

  state_e            state_q;
  logic [TYPE_W-1:0] type_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              bus_fault_q;
  logic              illegal_q;

  function automatic logic is_known(input logic [TYPE_W-1:0] t);
    return t inside {TyLui, TyAuipc, TyJal, TyJalr, TyLoad, TyStore, TyRimm, TyR, TyB};
  endfunction

  // Select bits [5:3] of the base control word; R and unknown types select 000.
  function automatic logic [2:0] base_sel(input logic [TYPE_W-1:0] t);
    logic [2:0] sel;
    sel = 3'b000;
    case (t)
      TyLoad, TyLui:        sel = 3'b011;
      TyStore, TyRimm:      sel = 3'b010;
      TyB, TyAuipc, TyJal:  sel = 3'b100;
      TyJalr:               sel = 3'b110;
      default:              sel = 3'b000;
    endcase
    return sel;
  endfunction

  logic timeout_hit;
  assign timeout_hit = TimeoutEn && (cnt_q == CntLast);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StFetch;
      type_q      <= '0;
      cnt_q       <= '0;
      bus_fault_q <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      case (state_q)
        StFetch: begin
          if (bus.imem_ready) begin
            type_q  <= bus.type_select;
            state_q <= StDecode;
          end else if (timeout_hit) begin
            bus_fault_q <= 1'b1;
            state_q     <= StTrap;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        StDecode: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
          if (is_known(type_q)) begin
            state_q <= StExec;
          end else begin
            illegal_q <= 1'b1;
            state_q   <= StTrap;
          end
`else
          // Unknown types fall through to EXEC and retire as a NOP.
          state_q <= StExec;
`endif
        end
        StExec: begin
          if (type_q == TyLoad || type_q == TyStore) begin
            cnt_q   <= '0;
            state_q <= StMem;
          end else if (type_q == TyB || !is_known(type_q)) begin
            cnt_q   <= '0;
            state_q <= StFetch;
          end else begin
            state_q <= StWb;
          end
        end
        StMem: begin
          if (bus.dmem_ready) begin
            if (type_q == TyLoad) begin
              state_q <= StWb;
            end else begin
              cnt_q   <= '0;
              state_q <= StFetch;
            end
          end else if (timeout_hit) begin
            bus_fault_q <= 1'b1;
            state_q     <= StTrap;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        StWb: begin
          cnt_q   <= '0;
          state_q <= StFetch;
        end
        StTrap:  state_q <= StTrap;
        default: state_q <= StTrap;
      endcase
    end
  end

  // Outputs decode the registered state; strobes and write enables are additionally gated by
  // rst_n so a reset cycle never fires a register/memory/PC write.
  logic       in_instr;
  logic [2:0] strobe;

  always_comb begin
    in_instr = (state_q == StDecode) || (state_q == StExec) || (state_q == StMem) ||
               (state_q == StWb);
    strobe   = 3'b000;
    pc_we    = 1'b0;
    case (state_q)
      StExec:  pc_we = (type_q == TyB) || !is_known(type_q);
      StMem: begin
        strobe[1] = (type_q == TyLoad);
        strobe[0] = (type_q == TyStore);
        pc_we     = (type_q == TyStore) && bus.dmem_ready;
      end
      StWb: begin
        strobe[2] = 1'b1;
        pc_we     = 1'b1;
      end
      default: ;
    endcase
    strobe   = rst_n ? strobe : 3'b000;
    pc_we    = pc_we && rst_n;
    ctrl_wrd = {(in_instr ? base_sel(type_q) : 3'b000), strobe};
  end

  assign bus.imem_req = (state_q == StFetch);
  assign ir_we        = (state_q == StFetch) && bus.imem_ready && rst_n;
  assign state        = state_q;
  assign halted       = (state_q == StTrap);
  assign bus_fault    = bus_fault_q;
`ifdef CTRL_ILLEGAL_TRAP_EN
  assign illegal      = illegal_q;
`else
  assign illegal      = 1'b0;
`endif

endmodule

// File: tb/tb_rv32i_multicycle_ctrl.sv
module tb_rv32i_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] ctrl_wrd;
  logic       ir_we;
  logic       pc_we;
  logic [2:0] state;
  logic       bus_fault;
  logic       illegal;
  logic       halted;
  int         total = 0;
  int         bad = 0;

  rv32i_multicycle_ctrl_if #(.TYPE_W(5)) bus ();

  rv32i_multicycle_ctrl #(
    .TYPE_W     (5),
    .MEM_TIMEOUT(4),
    .CNT_W      (5)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .ctrl_wrd (ctrl_wrd),
    .ir_we    (ir_we),
    .pc_we    (pc_we),
    .state    (state),
    .bus_fault(bus_fault),
    .illegal  (illegal),
    .halted   (halted)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bus.imem_ready  = 1'b0;
    bus.dmem_ready  = 1'b0;
    bus.type_select = 5'b00000;
    rst_n = 1'b0;
    tick();
    tick();
    @(negedge clk);
    total++; if (state !== 3'd0) begin bad++; $display("FAIL reset_state got %0d want 0", state); end
    total++; if (ctrl_wrd !== 6'b0) begin bad++; $display("FAIL reset_ctrl got %b want 000000", ctrl_wrd); end
    total++; if (bus.imem_req !== 1'b1) begin bad++; $display("FAIL reset_imem_req got %b want 1", bus.imem_req); end
    total++; if ({pc_we, ir_we, bus_fault, illegal, halted} !== 5'b0)
      begin bad++; $display("FAIL reset_flags got %b want 00000", {pc_we, ir_we, bus_fault, illegal, halted}); end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_r_type();
    logic [2:0] es [4];
    logic [5:0] ec [4];
    logic       ep [4];
    es = '{3'd0, 3'd1, 3'd2, 3'd4};
    ec = '{6'b000000, 6'b000000, 6'b000000, 6'b000100};
    ep = '{1'b0, 1'b0, 1'b0, 1'b1};
    bus.type_select = 5'b01100;
    bus.imem_ready  = 1'b1;
    bus.dmem_ready  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++; if (state !== es[i]) begin bad++; $display("FAIL r_type_state cyc%0d got %0d want %0d", i + 1, state, es[i]); end
      total++; if (ctrl_wrd !== ec[i]) begin bad++; $display("FAIL r_type_ctrl cyc%0d got %b want %b", i + 1, ctrl_wrd, ec[i]); end
      total++; if (pc_we !== ep[i]) begin bad++; $display("FAIL r_type_pc_we cyc%0d got %b want %b", i + 1, pc_we, ep[i]); end
      tick();
    end
    total++; if (state !== 3'd0) begin bad++; $display("FAIL r_type_next_fetch got %0d want 0", state); end
  endtask

  task automatic test_load_wait();
    logic [2:0] es [8];
    logic [5:0] ec [8];
    logic       ep [8];
    logic       dr [8];
    es = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4};
    ec = '{6'b000000, 6'b011000, 6'b011000, 6'b011010, 6'b011010, 6'b011010, 6'b011010,
           6'b011100};
    ep = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    // dmem_ready high outside MEM must be ignored.
    dr = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    bus.type_select = 5'b00000;
    bus.imem_ready  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.dmem_ready = dr[i];
      @(negedge clk);
      total++; if (state !== es[i]) begin bad++; $display("FAIL load_state cyc%0d got %0d want %0d", i + 1, state, es[i]); end
      total++; if (ctrl_wrd !== ec[i]) begin bad++; $display("FAIL load_ctrl cyc%0d got %b want %b", i + 1, ctrl_wrd, ec[i]); end
      total++; if (pc_we !== ep[i]) begin bad++; $display("FAIL load_pc_we cyc%0d got %b want %b", i + 1, pc_we, ep[i]); end
      tick();
    end
    total++; if (state !== 3'd0) begin bad++; $display("FAIL load_next_fetch got %0d want 0", state); end
    total++; if (bus_fault !== 1'b0) begin bad++; $display("FAIL load_bus_fault got %b want 0", bus_fault); end
  endtask

  task automatic test_back_to_back();
    logic [2:0] es [7];
    logic [5:0] ec [7];
    logic       ep [7];
    logic [4:0] ty [7];
    es = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd1, 3'd2, 3'd4};
    ec = '{6'b000000, 6'b100000, 6'b100000, 6'b000000, 6'b100000, 6'b100000, 6'b100100};
    ep = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    ty = '{5'b11000, 5'b11000, 5'b11000, 5'b11011, 5'b11011, 5'b11011, 5'b11011};
    bus.imem_ready = 1'b1;
    bus.dmem_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      bus.type_select = ty[i];
      @(negedge clk);
      total++; if (state !== es[i]) begin bad++; $display("FAIL b_jal_state cyc%0d got %0d want %0d", i + 1, state, es[i]); end
      total++; if (ctrl_wrd !== ec[i]) begin bad++; $display("FAIL b_jal_ctrl cyc%0d got %b want %b", i + 1, ctrl_wrd, ec[i]); end
      total++; if (pc_we !== ep[i]) begin bad++; $display("FAIL b_jal_pc_we cyc%0d got %b want %b", i + 1, pc_we, ep[i]); end
      tick();
    end
    total++; if (state !== 3'd0) begin bad++; $display("FAIL b_jal_next_fetch got %0d want 0", state); end
  endtask

  task automatic test_fetch_wait();
    logic [2:0] es [6];
    logic [5:0] ec [6];
    logic       ep [6];
    logic       iw [6];
    logic       ir [6];
    es = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd2, 3'd4};
    ec = '{6'b000000, 6'b000000, 6'b000000, 6'b011000, 6'b011000, 6'b011100};
    ep = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    iw = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    ir = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    bus.type_select = 5'b01101;
    bus.dmem_ready  = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.imem_ready = ir[i];
      @(negedge clk);
      total++; if (state !== es[i]) begin bad++; $display("FAIL lui_state cyc%0d got %0d want %0d", i + 1, state, es[i]); end
      total++; if (ctrl_wrd !== ec[i]) begin bad++; $display("FAIL lui_ctrl cyc%0d got %b want %b", i + 1, ctrl_wrd, ec[i]); end
      total++; if (pc_we !== ep[i]) begin bad++; $display("FAIL lui_pc_we cyc%0d got %b want %b", i + 1, pc_we, ep[i]); end
      total++; if (ir_we !== iw[i]) begin bad++; $display("FAIL lui_ir_we cyc%0d got %b want %b", i + 1, ir_we, iw[i]); end
      tick();
    end
    total++; if (state !== 3'd0) begin bad++; $display("FAIL lui_next_fetch got %0d want 0", state); end
  endtask

  task automatic test_illegal();
    bus.type_select = 5'b11111;
    bus.imem_ready  = 1'b1;
    bus.dmem_ready  = 1'b1;
    tick();
    @(negedge clk);
    total++; if (state !== 3'd1) begin bad++; $display("FAIL illegal_decode got %0d want 1", state); end
    tick();
`ifdef CTRL_ILLEGAL_TRAP_EN
    total++; if (state !== 3'd5) begin bad++; $display("FAIL illegal_trap_state got %0d want 5", state); end
    total++; if ({illegal, halted} !== 2'b11) begin bad++; $display("FAIL illegal_flags got %b want 11", {illegal, halted}); end
    do_reset();
    total++; if (illegal !== 1'b0) begin bad++; $display("FAIL illegal_cleared got %b want 0", illegal); end
`else
    @(negedge clk);
    total++; if (state !== 3'd2) begin bad++; $display("FAIL nop_exec_state got %0d want 2", state); end
    total++; if (ctrl_wrd !== 6'b000000) begin bad++; $display("FAIL nop_ctrl got %b want 000000", ctrl_wrd); end
    total++; if (pc_we !== 1'b1) begin bad++; $display("FAIL nop_pc_we got %b want 1", pc_we); end
    tick();
    total++; if (state !== 3'd0) begin bad++; $display("FAIL nop_next_fetch got %0d want 0", state); end
    total++; if (illegal !== 1'b0) begin bad++; $display("FAIL nop_illegal got %b want 0", illegal); end
`endif
  endtask

  task automatic test_reset_mid_load();
    bus.type_select = 5'b00000;
    bus.imem_ready  = 1'b1;
    bus.dmem_ready  = 1'b0;
    tick();
    tick();
    tick();
    total++; if (state !== 3'd3) begin bad++; $display("FAIL midrst_in_mem got %0d want 3", state); end
    rst_n = 1'b0;
    @(negedge clk);
    total++; if ({ctrl_wrd[2:0], pc_we} !== 4'b0) begin bad++; $display("FAIL midrst_strobes got %b want 0000", {ctrl_wrd[2:0], pc_we}); end
    tick();
    rst_n = 1'b1;
    bus.imem_ready = 1'b0;
    @(negedge clk);
    total++; if (state !== 3'd0) begin bad++; $display("FAIL midrst_state got %0d want 0", state); end
    total++; if (ctrl_wrd !== 6'b0) begin bad++; $display("FAIL midrst_ctrl got %b want 000000", ctrl_wrd); end
    total++; if (bus.imem_req !== 1'b1) begin bad++; $display("FAIL midrst_imem_req got %b want 1", bus.imem_req); end
    total++; if (bus_fault !== 1'b0) begin bad++; $display("FAIL midrst_bus_fault got %b want 0", bus_fault); end
    tick();
    @(negedge clk);
    total++; if (ctrl_wrd !== 6'b0) begin bad++; $display("FAIL midrst_no_wb got %b want 000000", ctrl_wrd); end
    tick();
  endtask

  task automatic test_store_timeout();
    logic [2:0] es [9];
    logic [5:0] ec [9];
    es = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd5, 3'd5};
    ec = '{6'b000000, 6'b010000, 6'b010000, 6'b010001, 6'b010001, 6'b010001, 6'b010001,
           6'b000000, 6'b000000};
    bus.type_select = 5'b01000;
    bus.imem_ready  = 1'b1;
    bus.dmem_ready  = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      total++; if (state !== es[i]) begin bad++; $display("FAIL store_to_state cyc%0d got %0d want %0d", i + 1, state, es[i]); end
      total++; if (ctrl_wrd !== ec[i]) begin bad++; $display("FAIL store_to_ctrl cyc%0d got %b want %b", i + 1, ctrl_wrd, ec[i]); end
      total++; if (pc_we !== 1'b0) begin bad++; $display("FAIL store_to_pc_we cyc%0d got %b want 0", i + 1, pc_we); end
      tick();
    end
    @(negedge clk);
    total++; if ({bus_fault, halted, bus.imem_req} !== 3'b110)
      begin bad++; $display("FAIL store_to_flags got %b want 110", {bus_fault, halted, bus.imem_req}); end
    tick();
    do_reset();
    @(negedge clk);
    total++; if ({state, bus_fault, halted} !== 5'b00000)
      begin bad++; $display("FAIL store_to_recover got %b want 00000", {state, bus_fault, halted}); end
    tick();
  endtask

  task automatic test_fetch_timeout();
    do_reset();
    bus.imem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++; if (state !== 3'd0) begin bad++; $display("FAIL fetch_to_wait cyc%0d got %0d want 0", i + 1, state); end
      tick();
    end
    @(negedge clk);
    total++; if ({state, bus_fault, halted} !== 5'b10111)
      begin bad++; $display("FAIL fetch_to_trap got %b want 10111", {state, bus_fault, halted}); end
    do_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_r_type();
    test_load_wait();
    test_back_to_back();
    test_fetch_wait();
    test_illegal();
    test_reset_mid_load();
    test_store_timeout();
    test_fetch_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
